// File: rtl/c_tile_writeback.sv
// Result writeback for the systolic array: buffers per-tile row bursts and writes them to C memory
// in row-major order. Optional build macro WB_SATURATE_EN clamps elements as signed values.
module c_tile_writeback #(
  parameter int WIDTH      = 4,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 16,
  parameter int M_SIZE     = 4,
  parameter int N_SIZE     = 4,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    data_output_valid,
  input  logic [WIDTH*DATA_W-1:0] row_data,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [ADDR_W-1:0]       mem_wr_addr,
  output logic [WIDTH*OUT_W-1:0]  mem_wr_data,
  output logic                    busy,
  output logic                    wb_done,
  output logic                    overflow
);
  localparam int TILES_M = (M_SIZE + WIDTH - 1) / WIDTH;
  localparam int TILES_N = (N_SIZE + WIDTH - 1) / WIDTH;
  localparam int RW      = $clog2(WIDTH + 1);
  localparam int TMW     = $clog2(TILES_M + 1);
  localparam int TNW     = $clog2(TILES_N + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int EW      = ADDR_W + WIDTH * OUT_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [RW-1:0]          row_cnt;
  logic [TMW-1:0]         tile_r;
  logic [TNW-1:0]         tile_c;
  logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [PW:0]            wr_ptr, rd_ptr;
  logic                   empty, full, push, pop, beat, last_beat;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH*OUT_W-1:0] conv_row;

  function automatic logic [OUT_W-1:0] convert(input logic [DATA_W-1:0] elem);
    logic [OUT_W-1:0] res;
`ifdef WB_SATURATE_EN
    // In range exactly when every bit from the output sign bit upward matches
    logic [DATA_W-OUT_W:0] upper;
    upper = elem[DATA_W-1:OUT_W-1];
    if (upper == '0 || upper == '1)
      res = elem[OUT_W-1:0];
    else if (elem[DATA_W-1])
      res = {1'b1, {(OUT_W-1){1'b0}}};
    else
      res = {1'b0, {(OUT_W-1){1'b1}}};
`else
    res = elem[OUT_W-1:0];
`endif
    return res;
  endfunction

`ifndef WB_SATURATE_EN
  logic unused_row_bits;
  assign unused_row_bits = ^row_data;
`endif

  always_comb begin
    conv_row = '0;
    for (int j = 0; j < WIDTH; j++)
      conv_row[j*OUT_W +: OUT_W] = convert(row_data[j*DATA_W +: DATA_W]);
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop       = !empty && mem_wr_ready;
  assign beat      = (state == RUN) && data_output_valid && !start;
  assign push      = beat && (!full || pop);
  assign last_beat = (row_cnt == RW'(WIDTH - 1)) && (tile_r == TMW'(TILES_M - 1)) &&
                     (tile_c == TNW'(TILES_N - 1));
  assign wr_addr   = ADDR_W'((32'(tile_r) * 32'(WIDTH) + 32'(row_cnt)) * 32'(TILES_N) + 32'(tile_c));
  assign head      = fifo_mem[rd_ptr[PW-1:0]];

  // Head is gated so stale storage never shows on the bus while the FIFO is empty
  assign mem_wr_valid = !empty;
  assign mem_wr_addr  = empty ? '0 : head[EW-1 -: ADDR_W];
  assign mem_wr_data  = empty ? '0 : head[WIDTH*OUT_W-1:0];
  assign busy         = (state != IDLE);
  assign wb_done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!start && beat && last_beat) state_nxt = FLUSH;
      FLUSH:   if (start) state_nxt = RUN;
               else if (empty) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters advance on every accepted-or-dropped beat so later addresses stay correct
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      tile_r   <= '0;
      tile_c   <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      row_cnt  <= '0;
      tile_r   <= '0;
      tile_c   <= '0;
      overflow <= 1'b0;
    end else if (beat) begin
      if (!push) overflow <= 1'b1;
      if (row_cnt == RW'(WIDTH - 1)) begin
        row_cnt <= '0;
        if (tile_r == TMW'(TILES_M - 1)) begin
          tile_r <= '0;
          tile_c <= (tile_c == TNW'(TILES_N - 1)) ? '0 : tile_c + TNW'(1);
        end else begin
          tile_r <= tile_r + TMW'(1);
        end
      end else begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {wr_addr, conv_row};
  end

endmodule

// File: tb/tb_c_tile_writeback.sv
// Scoreboard bench for c_tile_writeback on a 2x2-tile configuration with randomized rows and ready.
module tb_c_tile_writeback;
  localparam int WIDTH      = 4;
  localparam int DATA_W     = 32;
  localparam int OUT_W      = 16;
  localparam int M_SIZE     = 8;
  localparam int N_SIZE     = 8;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int TILES_M    = (M_SIZE + WIDTH - 1) / WIDTH;
  localparam int TILES_N    = (N_SIZE + WIDTH - 1) / WIDTH;
  localparam int BEATS      = WIDTH * TILES_M * TILES_N;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WIDTH*OUT_W-1:0] data;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    data_output_valid = 1'b0;
  logic [WIDTH*DATA_W-1:0] row_data = '0;
  logic                    mem_wr_valid;
  logic                    mem_wr_ready = 1'b0;
  logic [ADDR_W-1:0]       mem_wr_addr;
  logic [WIDTH*OUT_W-1:0]  mem_wr_data;
  logic                    busy, wb_done, overflow;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beat_idx = 0;
  int    ready_mode = 3;

  c_tile_writeback #(
    .WIDTH(WIDTH), .DATA_W(DATA_W), .OUT_W(OUT_W), .M_SIZE(M_SIZE), .N_SIZE(N_SIZE),
    .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_output_valid(data_output_valid),
    .row_data(row_data), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .busy(busy), .wb_done(wb_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference conversion: signed clamp to the output range, or plain low-bit truncation
  function automatic logic [OUT_W-1:0] ref_conv(input logic [DATA_W-1:0] e);
    longint v;
    v = longint'($signed(e));
`ifdef WB_SATURATE_EN
    if (v > (longint'(1) <<< (OUT_W-1)) - 1) v = (longint'(1) <<< (OUT_W-1)) - 1;
    else if (v < -(longint'(1) <<< (OUT_W-1))) v = -(longint'(1) <<< (OUT_W-1));
`endif
    return v[OUT_W-1:0];
  endfunction

  // Beat k of a job: row fastest, then tile row, then tile column
  function automatic logic [ADDR_W-1:0] ref_addr(input int k);
    int r, tr, tc, a;
    r  = k % WIDTH;
    tr = (k / WIDTH) % TILES_M;
    tc = k / (WIDTH * TILES_M);
    a  = (tr * WIDTH + r) * TILES_N + tc;
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_elem();
    logic [DATA_W-1:0] x;
    case ($urandom_range(0, 4))
      0:       x = DATA_W'($urandom_range(0, 1000));
      1:       begin x = DATA_W'($urandom_range(1, 1000)); x = -x; end
      2:       x = 32'h0001_0000;
      3:       x = 32'hFFFF_0000;
      default: x = $urandom();
    endcase
    return x;
  endfunction

  function automatic logic [WIDTH*DATA_W-1:0] make_row(input int k, input bit rnd);
    logic [WIDTH*DATA_W-1:0] d;
    for (int j = 0; j < WIDTH; j++)
      d[j*DATA_W +: DATA_W] = rnd ? rand_elem() : DATA_W'(k * WIDTH + j);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WIDTH*DATA_W-1:0] d, input bit accept);
    beat_t b;
    for (int j = 0; j < WIDTH; j++)
      b.data[j*OUT_W +: OUT_W] = ref_conv(d[j*DATA_W +: DATA_W]);
    b.addr = ref_addr(beat_idx);
    if (accept) exp_q.push_back(b);
    beat_idx++;
    row_data = d;
    data_output_valid = 1'b1;
    step();
    data_output_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    beat_idx = 0;
    check("busy_after_start", busy, 1);
    check("overflow_cleared", overflow, 0);
  endtask

  task automatic wait_room();
    int n = 0;
    while (exp_q.size() >= FIFO_DEPTH - 2 && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) fail("fifo_room_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!wb_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wb_done_seen", wb_done, 1);
    @(negedge clk);
    check("wb_done_pulse", wb_done, 0);
    check("busy_idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);
    step();
  endtask

  task automatic apply_stimulus(input int mode, input bit rnd, input int gap_max);
    ready_mode = mode;
    pulse_start();
    for (int k = 0; k < BEATS; k++) begin
      wait_room();
      repeat ($urandom_range(0, gap_max)) step();
      send_beat(make_row(k, rnd), 1'b1);
    end
    wait_done();
  endtask

  task automatic check_output(input string name);
    check({name, "_valid"}, mem_wr_valid, 0);
    check({name, "_addr"}, mem_wr_addr, 0);
    check({name, "_data"}, mem_wr_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, wb_done, 0);
    check({name, "_overflow"}, overflow, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_wr_ready = 1'b1;
        1:       mem_wr_ready = ~mem_wr_ready;
        2:       mem_wr_ready = 1'($urandom_range(0, 1));
        default: mem_wr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected beats on each handshake and checks hold-stability while stalled
  initial begin
    beat_t b, held;
    bit    stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid_held", mem_wr_valid, 1);
        check("stall_addr_stable", mem_wr_addr, held.addr);
        check("stall_data_stable", mem_wr_data, held.data);
      end
      stalled = 1'b0;
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          fail("spurious_write");
        end else begin
          b = exp_q.pop_front();
          check("write_addr", mem_wr_addr, b.addr);
          check("write_data", mem_wr_data, b.data);
        end
      end else if (mem_wr_valid) begin
        stalled = 1'b1;
        held.addr = mem_wr_addr;
        held.data = mem_wr_data;
      end
      if (wb_done) check("done_after_all_writes", exp_q.size(), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) step();
    check_output("reset");
    rst_n = 1'b1;
    step();

    // Ordered rows, always ready
    apply_stimulus(0, 1'b0, 0);

    // Beats while idle must be ignored
    row_data = make_row(0, 1'b1);
    data_output_valid = 1'b1;
    repeat (2) step();
    data_output_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_valid", mem_wr_valid, 0);
    check("idle_ignore_busy", busy, 0);
    step();

    apply_stimulus(1, 1'b1, 1);
    apply_stimulus(2, 1'b1, 3);
    apply_stimulus(2, 1'b1, 0);

    // Fill the FIFO exactly with ready held low, then one beat too many
    ready_mode = 3;
    step();
    pulse_start();
    for (int k = 0; k < FIFO_DEPTH; k++) send_beat(make_row(k, 1'b1), 1'b1);
    repeat (20) step();
    check("full_no_overflow", overflow, 0);
    check("full_valid", mem_wr_valid, 1);
    check("full_head_addr", mem_wr_addr, exp_q[0].addr);
    send_beat(make_row(FIFO_DEPTH, 1'b1), 1'b0);
    check("overflow_set", overflow, 1);
    ready_mode = 0;
    for (int k = FIFO_DEPTH + 1; k < BEATS; k++) begin
      wait_room();
      send_beat(make_row(k, 1'b1), 1'b1);
    end
    wait_done();
    check("overflow_sticky", overflow, 1);

    // Reset in the middle of a burst discards everything
    ready_mode = 3;
    step();
    pulse_start();
    for (int k = 0; k < 6; k++) send_beat(make_row(k, 1'b1), 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("midreset");
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    apply_stimulus(0, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
